databus_axi_read_bridge: RTL and testbench



---
 rtl/databus_axi_read_bridge.sv | 135 +++++++++++++
 tb/tb_databus_axi_read_bridge.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/databus_axi_read_bridge.sv
// Databus-to-AXI4 read bridge: one INCR burst per databus request, beats streamed back.
// Define DATABUS_AXI_READ_SKID_EN to place a 2-entry register slice on the R path.
module databus_axi_read_bridge #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 8,
    parameter int AXI_ID_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  databus_valid,
    input  logic [AXI_ADDR_W-1:0] databus_addr,
    input  logic [LEN_W-1:0]      databus_len,
    output logic                  databus_ready,
    output logic [AXI_DATA_W-1:0] databus_rdata,
    output logic                  databus_last,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [LEN_W-1:0]      m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [AXI_ID_W-1:0]   m_axi_arid,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    output logic                  error
);
    localparam int SIZE = $clog2(AXI_DATA_W / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] beat_cnt;
    logic             accept, r_xfer, cnt_last, err_beat, done_evt;
    wire              unused_rresp = m_axi_rresp[0];

    assign m_axi_arvalid = (state == ADDR);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = '0;

    assign accept   = (state == IDLE) && databus_valid;
    assign r_xfer   = m_axi_rvalid && m_axi_rready;
    assign cnt_last = (beat_cnt == m_axi_arlen);
    // The beat counter decides the end of burst; rlast is only cross-checked.
    assign err_beat = r_xfer && (m_axi_rresp[1] || (m_axi_rlast != cnt_last));

`ifdef DATABUS_AXI_READ_SKID_EN
    logic [1:0][AXI_DATA_W-1:0] sk_data;
    logic [1:0]                 sk_last;
    logic [1:0]                 sk_cnt;
    logic                       wr_ptr, rd_ptr, rx_done, pop;

    // rready depends only on registered state, never on databus_valid.
    assign m_axi_rready  = (state == DATA) && (sk_cnt != 2'd2) && !rx_done;
    assign databus_ready = (sk_cnt != 2'd0);
    assign databus_rdata = databus_ready ? sk_data[rd_ptr] : '0;
    assign databus_last  = databus_ready && sk_last[rd_ptr];
    assign pop           = databus_ready && databus_valid;
    assign done_evt      = pop && sk_last[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk_data <= '0;
            sk_last <= '0;
            sk_cnt  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            rx_done <= 1'b0;
        end else if (accept) begin
            sk_cnt  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            rx_done <= 1'b0;
        end else begin
            if (r_xfer) begin
                sk_data[wr_ptr] <= m_axi_rdata;
                sk_last[wr_ptr] <= cnt_last;
                wr_ptr          <= ~wr_ptr;
                if (cnt_last)
                    rx_done <= 1'b1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (r_xfer && !pop)
                sk_cnt <= sk_cnt + 2'd1;
            else if (!r_xfer && pop)
                sk_cnt <= sk_cnt - 2'd1;
        end
    end
`else
    assign m_axi_rready  = (state == DATA) && databus_valid;
    assign databus_ready = (state == DATA) && m_axi_rvalid;
    assign databus_rdata = (state == DATA) ? m_axi_rdata : '0;
    assign databus_last  = databus_ready && cnt_last;
    assign done_evt      = r_xfer && cnt_last;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (databus_valid)  state_nxt = ADDR;
            ADDR:    if (m_axi_arready)  state_nxt = DATA;
            DATA:    if (done_evt)       state_nxt = RELEASE;
            RELEASE: if (!databus_valid) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
            beat_cnt     <= '0;
            error        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                m_axi_araddr <= databus_addr;
                m_axi_arlen  <= databus_len;
                beat_cnt     <= '0;
                error        <= 1'b0;
            end else begin
                if (r_xfer && !cnt_last)
                    beat_cnt <= beat_cnt + 1'b1;
                if (err_beat)
                    error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_databus_axi_read_bridge.sv
// Directed bench for databus_axi_read_bridge (pass-through R path build).
module tb_databus_axi_read_bridge;
    localparam int AW = 32, DW = 32, LW = 8, IW = 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          databus_valid = 1'b0;
    logic [AW-1:0] databus_addr = '0;
    logic [LW-1:0] databus_len = '0;
    logic          databus_ready, databus_last;
    logic [DW-1:0] databus_rdata;
    logic          m_axi_arvalid, m_axi_arready = 1'b0;
    logic [AW-1:0] m_axi_araddr;
    logic [LW-1:0] m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic [IW-1:0] m_axi_arid;
    logic          m_axi_rvalid = 1'b0, m_axi_rready;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic          m_axi_rlast = 1'b0;
    logic          error;

    int checks = 0, errors = 0;

    databus_axi_read_bridge #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW), .AXI_ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .databus_valid(databus_valid), .databus_addr(databus_addr), .databus_len(databus_len),
        .databus_ready(databus_ready), .databus_rdata(databus_rdata), .databus_last(databus_last),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arid(m_axi_arid), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] base;
        logic [7:0]  stall;      // beat i preceded by one cycle of databus_valid=0
        int          rresp_beat; // beat carrying SLVERR, -1 none
        int          rlast_beat; // beat carrying an early rlast, -1 none
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic err_exp;
        err_exp = 1'b0;
        @(negedge clk);
        databus_valid = 1'b1; databus_addr = v.addr; databus_len = v.len;
        @(negedge clk);
        chk("arvalid_rise", m_axi_arvalid, 1);
        chk("araddr", m_axi_araddr, v.addr);
        chk("arlen", m_axi_arlen, v.len);
        chk("arsize", m_axi_arsize, 2);
        chk("arburst", m_axi_arburst, 1);
        chk("arid", m_axi_arid, 0);
        chk("error_cleared", error, 0);
        @(negedge clk);
        chk("arvalid_hold", m_axi_arvalid, 1);
        chk("araddr_hold", m_axi_araddr, v.addr);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        chk("arvalid_drop", m_axi_arvalid, 0);
        for (int i = 0; i <= int'(v.len); i++) begin
            if (v.stall[i]) begin
                databus_valid = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = v.base + i;
                #1 chk("rready_stall", m_axi_rready, 0);
                @(negedge clk);
            end
            databus_valid = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = v.base + i;
            m_axi_rresp = (i == v.rresp_beat) ? 2'b10 : 2'b00;
            m_axi_rlast = (i == int'(v.len)) || (i == v.rlast_beat);
            #1;
            chk("rready", m_axi_rready, 1);
            chk("db_ready", databus_ready, 1);
            chk("db_rdata", databus_rdata, v.base + i);
            chk("db_last", databus_last, i == int'(v.len));
            if (i == v.rresp_beat || (i == v.rlast_beat && i != int'(v.len)))
                err_exp = 1'b1;
            @(negedge clk);
            chk("error", error, err_exp);
        end
        // Valid held high after the burst: R path closed, no new AR.
        m_axi_rvalid = 1'b1; m_axi_rresp = '0; m_axi_rlast = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("release_rready", m_axi_rready, 0);
            chk("release_db_ready", databus_ready, 0);
            @(negedge clk);
            chk("release_no_ar", m_axi_arvalid, 0);
        end
        m_axi_rvalid = 1'b0; databus_valid = 1'b0;
        @(negedge clk);
        chk("idle_no_ar", m_axi_arvalid, 0);
    endtask

    initial begin
        vecs[0] = '{32'h1000, 8'd3, 32'hA0, 8'h00, -1, -1};
        vecs[1] = '{32'h1000, 8'd3, 32'hA0, 8'h0A, -1, -1};
        vecs[2] = '{32'h2000, 8'd0, 32'hDEADBEEF, 8'h00, -1, -1};
        vecs[3] = '{32'h1100, 8'd3, 32'hB0, 8'h00, 1, -1};
        vecs[4] = '{32'h1200, 8'd3, 32'hC0, 8'h00, -1, 1};
        vecs[5] = '{32'h1300, 8'd1, 32'hD0, 8'h00, -1, -1};

        @(negedge clk);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_db_ready", databus_ready, 0);
        chk("rst_db_last", databus_last, 0);
        chk("rst_db_rdata", databus_rdata, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 6; n++)
            run_vec(vecs[n]);

        // Reset after 2 of 8 beats, then a fresh request.
        @(negedge clk);
        databus_valid = 1'b1; databus_addr = 32'h3000; databus_len = 8'd7;
        @(negedge clk);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = 32'hE0 + i; m_axi_rresp = 2'b10;
            @(negedge clk);
        end
        chk("pre_rst_error", error, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_araddr", m_axi_araddr, 0);
        chk("mid_rst_arlen", m_axi_arlen, 0);
        chk("mid_rst_rready", m_axi_rready, 0);
        chk("mid_rst_db_ready", databus_ready, 0);
        chk("mid_rst_db_last", databus_last, 0);
        chk("mid_rst_db_rdata", databus_rdata, 0);
        chk("mid_rst_error", error, 0);
        @(negedge clk);
        rst = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = '0; databus_valid = 1'b0;
        @(negedge clk);
        run_vec('{32'h4000, 8'd2, 32'hF0, 8'h00, -1, -1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
